// File: rtl/adc_spi_slave.sv
// SPI mode-0 responder for the 3-byte ADC register-access protocol, oversampled in the clk domain.
// Optional ADC_SPI_SLAVE_STREAM_EN: extra data bytes continue at reg_addr+1 while CS stays low.
module adc_spi_slave #(
   parameter int unsigned ADDR_W      = 13,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_sdi,
   output logic              spi_sdo,
   output logic              spi_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_wr_en,
   output logic [7:0]        reg_wr_data,
   output logic              reg_rd_req,
   input  logic [7:0]        reg_rd_data,
   output logic              frame_err,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_DATA, S_DONE} state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q;
   logic                   cs_d1_q, sclk_d1_q;
   logic                   cs_s, sclk_s, sdi_s;
   logic                   cs_fall, cs_rise, sclk_rise, sclk_fall, boundary;

   state_t                 state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [7:0]             rx_q, rx_d, rx_shift;
   logic [7:0]             tx_q, tx_d;
   logic                   rw_q, rw_d;
   logic [4:0]             hi_q, hi_d;
   logic [12:0]            full_addr;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   wr_en_q, wr_en_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   rd_req_q, rd_req_d;
   logic                   err_q, err_d;
   logic                   oe_q, oe_d;
   logic                   sdo_q, sdo_d;
   logic                   bdone_q, bdone_d;
   logic                   busy_q;

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign cs_fall   = ~cs_s & cs_d1_q;
   assign cs_rise   = cs_s & ~cs_d1_q;
   assign sclk_rise = sclk_s & ~sclk_d1_q & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_d1_q & ~cs_s;
   // A streamed frame may end cleanly right after any completed data byte
   assign boundary  = bdone_q && (cnt_q == 5'd16) && (state_q == S_DATA || state_q == S_FETCH);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      rw_d      = rw_q;
      hi_d      = hi_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      rd_req_d  = 1'b0;
      err_d     = 1'b0;
      oe_d      = oe_q;
      sdo_d     = sdo_q;
      bdone_d   = bdone_q;
      rx_shift  = {rx_q[6:0], sdi_s};
      full_addr = {hi_q, rx_shift};
      if (cs_fall) begin
         state_d = S_HDR0;
         cnt_d   = '0;
         rx_d    = '0;
         oe_d    = 1'b0;
         sdo_d   = 1'b0;
         bdone_d = 1'b0;
      end else if (cs_rise) begin
         if (state_q != S_IDLE && state_q != S_DONE && !boundary) err_d = 1'b1;
         state_d = S_IDLE;
         oe_d    = 1'b0;
         sdo_d   = 1'b0;
      end else begin
         case (state_q)
            S_HDR0: if (sclk_rise) begin
               rx_d  = rx_shift;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  rw_d    = rx_shift[7];
                  hi_d    = rx_shift[4:0];
                  state_d = S_HDR1;
               end
            end
            S_HDR1: if (sclk_rise) begin
               rx_d  = rx_shift;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  addr_d = full_addr[ADDR_W-1:0];
                  if (rw_q) begin
                     rd_req_d = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            // Wait out the request cycle so the bank gets one full clk to respond
            S_FETCH: if (!rd_req_q) begin
               tx_d    = reg_rd_data;
               sdo_d   = reg_rd_data[7];
               oe_d    = 1'b1;
               state_d = S_DATA;
            end
            S_DATA: if (sclk_rise) begin
               rx_d    = rx_shift;
               cnt_d   = cnt_q + 5'd1;
               bdone_d = 1'b0;
               if (bdone_q && !rw_q) addr_d = addr_q + ADDR_W'(1);
               if (cnt_q == 5'd23) begin
                  if (!rw_q) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = rx_shift;
                  end
`ifdef ADC_SPI_SLAVE_STREAM_EN
                  cnt_d   = 5'd16;
                  bdone_d = 1'b1;
                  if (rw_q) begin
                     addr_d   = addr_q + ADDR_W'(1);
                     rd_req_d = 1'b1;
                     state_d  = S_FETCH;
                  end
`else
                  state_d = S_DONE;
`endif
               end
            end else if (sclk_fall && rw_q && cnt_q != 5'd16) begin
               // The fall before the first data rise must not consume bit 7
               tx_d  = {tx_q[6:0], 1'b0};
               sdo_d = tx_q[6];
            end
            S_DONE: if (sclk_fall) begin
               oe_d  = 1'b0;
               sdo_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         sdi_sync_q  <= '0;
         cs_d1_q     <= 1'b1;
         sclk_d1_q   <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         rw_q        <= 1'b0;
         hi_q        <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         rd_req_q    <= 1'b0;
         err_q       <= 1'b0;
         oe_q        <= 1'b0;
         sdo_q       <= 1'b0;
         bdone_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
         cs_d1_q     <= cs_s;
         sclk_d1_q   <= sclk_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         rw_q        <= rw_d;
         hi_q        <= hi_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         rd_req_q    <= rd_req_d;
         err_q       <= err_d;
         oe_q        <= oe_d;
         sdo_q       <= sdo_d;
         bdone_q     <= bdone_d;
         busy_q      <= ~cs_s;
      end
   end

   assign spi_sdo     = sdo_q;
   assign spi_oe      = oe_q;
   assign reg_addr    = addr_q;
   assign reg_wr_en   = wr_en_q;
   assign reg_wr_data = wr_data_q;
   assign reg_rd_req  = rd_req_q;
   assign frame_err   = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_adc_spi_slave.sv
// Directed bench for adc_spi_slave: write, read, abort, mid-frame reset and over-long frames.
module tb_adc_spi_slave;

   logic        clk = 1'b0;
   logic        rst, spi_cs_n, spi_sclk, spi_sdi;
   logic        spi_sdo, spi_oe, reg_wr_en, reg_rd_req, frame_err, busy;
   logic [12:0] reg_addr;
   logic [7:0]  reg_wr_data;
   logic [7:0]  reg_rd_data = 8'h00;
   logic [7:0]  rd_val = 8'h00;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   int unsigned wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
   logic [12:0] wr_addr_last = '0, wr_addr_prev = '0, rd_addr_last = '0;
   logic [7:0]  wr_data_last = '0, wr_data_prev = '0;

   logic [31:0] miso_cap, oe_cap;
   logic        busy_seen;

   always #5 clk = ~clk;

   adc_spi_slave #(.ADDR_W(13), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
      .spi_sdo(spi_sdo), .spi_oe(spi_oe), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
      .reg_wr_data(reg_wr_data), .reg_rd_req(reg_rd_req), .reg_rd_data(reg_rd_data),
      .frame_err(frame_err), .busy(busy)
   );

   // Register bank answers a read request one clk later
   always @(posedge clk) if (reg_rd_req) reg_rd_data <= rd_val;

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_cnt       = wr_cnt + 1;
         wr_addr_prev = wr_addr_last;
         wr_data_prev = wr_data_last;
         wr_addr_last = reg_addr;
         wr_data_last = reg_wr_data;
      end
      if (reg_rd_req) begin
         rd_cnt       = rd_cnt + 1;
         rd_addr_last = reg_addr;
      end
      if (frame_err) err_cnt = err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // SCLK half period is 8 clks; data is shifted out MSB-first from data[31]
   task automatic spi_xfer(input logic [31:0] data, input int unsigned nbits, input bit end_cs);
      miso_cap  = '0;
      oe_cap    = '0;
      spi_cs_n  = 1'b0;
      repeat (8) @(negedge clk);
      busy_seen = busy;
      for (int unsigned i = 0; i < nbits; i++) begin
         spi_sdi = data[31-i];
         repeat (8) @(negedge clk);
         miso_cap = {miso_cap[30:0], spi_sdo};
         oe_cap   = {oe_cap[30:0], spi_oe};
         spi_sclk = 1'b1;
         repeat (8) @(negedge clk);
         spi_sclk = 1'b0;
      end
      if (end_cs) begin
         repeat (8) @(negedge clk);
         spi_cs_n = 1'b1;
         repeat (12) @(negedge clk);
      end
   endtask

   int unsigned w0, r0, e0;

   initial begin
      rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_sdi = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_oe", spi_oe, 0);
      check("rst_addr", reg_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_strobes", {reg_wr_en, reg_rd_req, frame_err}, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Plain write
      w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h0123A5_00, 24, 1'b1);
      check("wr_count", wr_cnt - w0, 1);
      check("wr_addr", wr_addr_last, 13'h0123);
      check("wr_data", wr_data_last, 8'hA5);
      check("wr_err", err_cnt - e0, 0);
      check("wr_oe", oe_cap, 0);
      check("wr_busy", busy_seen, 1);
      check("wr_idle_busy", busy, 0);

      // Read of the top address
      rd_val = 8'h3C; r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h9FFF00_00, 24, 1'b1);
      check("rd_count", rd_cnt - r0, 1);
      check("rd_addr", rd_addr_last, 13'h1FFF);
      check("rd_miso", miso_cap[7:0], 8'h3C);
      check("rd_oe_window", oe_cap[23:0], 24'h0000FF);
      check("rd_oe_after", spi_oe, 0);
      check("rd_no_wr", wr_cnt - w0, 0);
      check("rd_err", err_cnt - e0, 0);

      // Abort after 10 SCLKs, then a clean frame
      w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h0123A5_00, 10, 1'b1);
      check("abort_err", err_cnt - e0, 1);
      check("abort_no_wr", wr_cnt - w0, 0);
      check("abort_busy", busy, 0);
      spi_xfer(32'h023456_00, 24, 1'b1);
      check("post_abort_wr", wr_cnt - w0, 1);
      check("post_abort_addr", wr_addr_last, 13'h0234);
      check("post_abort_data", wr_data_last, 8'h56);
      check("post_abort_err", err_cnt - e0, 1);

      // Reset at bit 20 of a read
      rd_val = 8'hC3; w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h800300_00, 20, 1'b0);
      check("pre_rst_oe", spi_oe, 1);
      rst = 1'b1;
      #1;
      check("midrst_oe", spi_oe, 0);
      check("midrst_strobes", {reg_wr_en, reg_rd_req, frame_err}, 0);
      check("midrst_addr", reg_addr, 0);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      spi_xfer(32'h000577_00, 24, 1'b1);
      check("post_rst_wr", wr_cnt - w0, 1);
      check("post_rst_addr", wr_addr_last, 13'h0005);
      check("post_rst_data", wr_data_last, 8'h77);
      check("post_rst_err", err_cnt - e0, 0);

`ifdef ADC_SPI_SLAVE_STREAM_EN
      w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h1FFF1122, 32, 1'b1);
      check("stream_count", wr_cnt - w0, 2);
      check("stream_addr0", wr_addr_prev, 13'h1FFF);
      check("stream_data0", wr_data_prev, 8'h11);
      check("stream_addr1", wr_addr_last, 13'h0000);
      check("stream_data1", wr_data_last, 8'h22);
      check("stream_err", err_cnt - e0, 0);
`else
      w0 = wr_cnt; e0 = err_cnt;
      spi_xfer(32'h004099EE, 32, 1'b1);
      check("long_count", wr_cnt - w0, 1);
      check("long_addr", wr_addr_last, 13'h0040);
      check("long_data", wr_data_last, 8'h99);
      check("long_err", err_cnt - e0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
